// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg
// Shared definitions for the PE array sequencer:
//   - seq_state_t : frame sequencer state encoding
//   - PIX_W       : pixel channel width
//   - SAT_MAX     : saturated channel value
//   - clog2()     : elaboration-time ceil(log2()) helper
package pe_seq_pkg;

    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
        SUM_GO,
        SUM_WAIT,
        AVG,
        BG_GO,
        BG_WAIT,
        DONE
    } seq_state_t;

    // ceil(log2(value)); clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_seq_divider.sv
// pe_seq_divider
// Restoring divider by the constant NUM_PROC, one quotient bit per cycle.
// The quotient is saturated to 8 bits and held until the next completed
// division. With NUM_PROC = 1 the divide is bypassed and completes in one
// cycle.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   start_i      load dividend_i and begin dividing
//   dividend_i   total to divide (SUM_W + clog2(NUM_PROC) bits)
//   busy_o       division in progress
//   valid_o      last step this cycle; quot_o updates at the next edge
//   quot_o       saturated 8-bit quotient
module pe_seq_divider
    import pe_seq_pkg::*;
#(
    parameter int NUM_PROC = 2,
    parameter int SUM_W    = 32
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                start_i,
    input  logic [SUM_W+clog2(NUM_PROC)-1:0]    dividend_i,
    output logic                                busy_o,
    output logic                                valid_o,
    output logic [PIX_W-1:0]                    quot_o
);

    localparam int TOT_W = SUM_W + clog2(NUM_PROC);
    localparam int DW    = clog2(NUM_PROC) + 1;
    localparam int LAT   = (NUM_PROC == 1) ? 1 : TOT_W;
    localparam int CW    = clog2(LAT + 1);
    localparam logic [DW:0] DIVISOR = (DW + 1)'(NUM_PROC);

    // dvd_q shifts the dividend out of its MSB while quotient bits enter
    // at the LSB; after TOT_W steps it holds the full quotient.
    logic [TOT_W-1:0] dvd_q, dvd_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [CW-1:0]    cnt_q;
    logic [PIX_W-1:0] quot_q;
    logic [DW:0]      shifted;
    logic [DW:0]      diff;
    logic             ge;
    logic [TOT_W-1:0] result;

    function automatic logic [PIX_W-1:0] saturate(input logic [TOT_W-1:0] q);
        if ((q >> PIX_W) != '0) return SAT_MAX;
        return q[PIX_W-1:0];
    endfunction

    always_comb begin
        shifted = {rem_q, dvd_q[TOT_W-1]};
        diff    = shifted - DIVISOR;
        ge      = (shifted >= DIVISOR);
        rem_d   = ge ? diff[DW-1:0] : shifted[DW-1:0];
        dvd_d   = {dvd_q[TOT_W-2:0], ge};
        result  = (NUM_PROC == 1) ? dvd_q : dvd_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
        end else if (start_i) begin
            dvd_q <= dividend_i;
            rem_q <= '0;
            cnt_q <= CW'(LAT);
        end else if (cnt_q != '0) begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) quot_q <= saturate(result);
        end
    end

    assign busy_o  = (cnt_q != '0);
    assign valid_o = (cnt_q == CW'(1));
    assign quot_o  = quot_q;

endmodule

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer
// Frame controller for NUM_PROC background-removal PEs: runs the sum pass,
// averages the per-channel sums into the expected background colour,
// broadcasts config and runs the removal pass, then holds done until the
// host acknowledges.
// Ports:
//   Clk, Reset                         clock, asynchronous active-high reset
//   start, host_ack                    host handshake
//   threshold_in, bg_*_in              frame config, latched on accepted start
//   busy, done, err                    host status
//   pe_start_sum, pe_start_bg, pe_ack  PE control
//   pe_sum_done, pe_bg_done            PE completion levels
//   *_sum_flat                         PE k sum at [k*SUM_W +: SUM_W]
//   *_exp                              averaged expected background
//   threshold, desired_bg_*            registered broadcast config
// Build option: PE_SEQ_TIMEOUT_EN enables the wait-state watchdog
// (TIMEOUT_CYC); without it err is tied low and waits are unbounded.
//
// state    | meaning
// IDLE     | waiting for host start
// SUM_GO   | one-cycle sum start pulse to all PEs
// SUM_WAIT | collecting sum-done bits
// AVG      | dividing channel totals by NUM_PROC
// BG_GO    | one-cycle removal start pulse to all PEs
// BG_WAIT  | collecting removal-done bits
// DONE     | done held until host_ack
module pe_array_sequencer
    import pe_seq_pkg::*;
#(
    parameter int NUM_PROC    = 2,
    parameter int SUM_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      host_ack,
    input  logic [7:0]                threshold_in,
    input  logic [7:0]                bg_r_in,
    input  logic [7:0]                bg_g_in,
    input  logic [7:0]                bg_b_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [NUM_PROC-1:0]       pe_start_sum,
    output logic [NUM_PROC-1:0]       pe_start_bg,
    output logic                      pe_ack,
    input  logic [NUM_PROC-1:0]       pe_sum_done,
    input  logic [NUM_PROC-1:0]       pe_bg_done,
    input  logic [NUM_PROC*SUM_W-1:0] red_sum_flat,
    input  logic [NUM_PROC*SUM_W-1:0] green_sum_flat,
    input  logic [NUM_PROC*SUM_W-1:0] blue_sum_flat,
    output logic [7:0]                red_exp,
    output logic [7:0]                green_exp,
    output logic [7:0]                blue_exp,
    output logic [7:0]                threshold,
    output logic [7:0]                desired_bg_r,
    output logic [7:0]                desired_bg_g,
    output logic [7:0]                desired_bg_b
);

    localparam int TOT_W = SUM_W + clog2(NUM_PROC);

    seq_state_t          state_q, state_d;
    logic                ack_q, ack_d;
    logic [NUM_PROC-1:0] sum_mask_q, bg_mask_q;
    logic [NUM_PROC-1:0] sum_mask_now, bg_mask_now;
    logic [7:0]          thr_q, bgr_q, bgg_q, bgb_q;
    logic [TOT_W-1:0]    tot_r, tot_g, tot_b;
    logic                div_start;
    logic [2:0]          div_busy, div_valid;
    logic                to_expired;
    logic                accept;

    assign accept       = (state_q == IDLE) && start;
    // Done levels count in the same cycle they are seen so a single-cycle
    // pulse is enough to finish a wait.
    assign sum_mask_now = sum_mask_q | pe_sum_done;
    assign bg_mask_now  = bg_mask_q | pe_bg_done;

    always_comb begin
        tot_r = '0;
        tot_g = '0;
        tot_b = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            tot_r = tot_r + TOT_W'(red_sum_flat[k*SUM_W +: SUM_W]);
            tot_g = tot_g + TOT_W'(green_sum_flat[k*SUM_W +: SUM_W]);
            tot_b = tot_b + TOT_W'(blue_sum_flat[k*SUM_W +: SUM_W]);
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = SUM_GO;
            SUM_GO: state_d = SUM_WAIT;
            SUM_WAIT: begin
                if (&sum_mask_now) begin
                    state_d   = AVG;
                    ack_d     = 1'b1;
                    div_start = 1'b1;
                end else if (to_expired) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end
            end
            // The idle escape only matters if the dividers were somehow
            // never started; it keeps the FSM from stalling in AVG.
            AVG: if ((&div_valid) || !(|div_busy)) state_d = BG_GO;
            BG_GO: state_d = BG_WAIT;
            BG_WAIT: begin
                if (&bg_mask_now) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end else if (to_expired) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end
            end
            DONE: if (host_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            sum_mask_q <= '0;
            bg_mask_q  <= '0;
            thr_q      <= '0;
            bgr_q      <= '0;
            bgg_q      <= '0;
            bgb_q      <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (accept) begin
                sum_mask_q <= '0;
                bg_mask_q  <= '0;
                thr_q      <= threshold_in;
                bgr_q      <= bg_r_in;
                bgg_q      <= bg_g_in;
                bgb_q      <= bg_b_in;
            end
            if (state_q == SUM_WAIT) sum_mask_q <= sum_mask_now;
            if (state_q == BG_WAIT)  bg_mask_q  <= bg_mask_now;
        end
    end

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    logic            to_fire;

    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign to_fire    = to_expired &&
                        (((state_q == SUM_WAIT) && !(&sum_mask_now)) ||
                         ((state_q == BG_WAIT)  && !(&bg_mask_now)));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state_q == SUM_GO) || (state_q == BG_GO))
                to_cnt_q <= '0;
            else if ((state_q == SUM_WAIT) || (state_q == BG_WAIT))
                to_cnt_q <= to_cnt_q + TO_W'(1);
            if (accept)
                err_q <= 1'b0;
            else if (to_fire)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign to_expired = 1'b0;
    assign err        = 1'b0;
`endif

    pe_seq_divider #(.NUM_PROC(NUM_PROC), .SUM_W(SUM_W)) u_div_r (
        .Clk(Clk), .Reset(Reset), .start_i(div_start), .dividend_i(tot_r),
        .busy_o(div_busy[0]), .valid_o(div_valid[0]), .quot_o(red_exp)
    );

    pe_seq_divider #(.NUM_PROC(NUM_PROC), .SUM_W(SUM_W)) u_div_g (
        .Clk(Clk), .Reset(Reset), .start_i(div_start), .dividend_i(tot_g),
        .busy_o(div_busy[1]), .valid_o(div_valid[1]), .quot_o(green_exp)
    );

    pe_seq_divider #(.NUM_PROC(NUM_PROC), .SUM_W(SUM_W)) u_div_b (
        .Clk(Clk), .Reset(Reset), .start_i(div_start), .dividend_i(tot_b),
        .busy_o(div_busy[2]), .valid_o(div_valid[2]), .quot_o(blue_exp)
    );

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign pe_start_sum = {NUM_PROC{state_q == SUM_GO}};
    assign pe_start_bg  = {NUM_PROC{state_q == BG_GO}};
    assign pe_ack       = ack_q;
    assign threshold    = thr_q;
    assign desired_bg_r = bgr_q;
    assign desired_bg_g = bgg_q;
    assign desired_bg_b = bgb_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
module tb_pe_array_sequencer;

    localparam int NP    = 2;
    localparam int SW    = 32;
    localparam int TO_C  = 16;

    logic           Clk = 1'b0;
    logic           Reset, start, host_ack;
    logic [7:0]     threshold_in, bg_r_in, bg_g_in, bg_b_in;
    logic           busy, done, err, pe_ack;
    logic [NP-1:0]  pe_start_sum, pe_start_bg, pe_sum_done, pe_bg_done;
    logic [NP*SW-1:0] red_sum_flat, green_sum_flat, blue_sum_flat;
    logic [7:0]     red_exp, green_exp, blue_exp;
    logic [7:0]     threshold, desired_bg_r, desired_bg_g, desired_bg_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] s_r[NP], s_g[NP], s_b[NP];
    int          sd[NP], bd[NP];
    logic [7:0]  cfg_thr, cfg_r, cfg_g, cfg_b;
    logic [7:0]  prev_r, prev_g, prev_b;

    pe_array_sequencer #(.NUM_PROC(NP), .SUM_W(SW), .TIMEOUT_CYC(TO_C)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .host_ack(host_ack),
        .threshold_in(threshold_in), .bg_r_in(bg_r_in), .bg_g_in(bg_g_in),
        .bg_b_in(bg_b_in), .busy(busy), .done(done), .err(err),
        .pe_start_sum(pe_start_sum), .pe_start_bg(pe_start_bg), .pe_ack(pe_ack),
        .pe_sum_done(pe_sum_done), .pe_bg_done(pe_bg_done),
        .red_sum_flat(red_sum_flat), .green_sum_flat(green_sum_flat),
        .blue_sum_flat(blue_sum_flat), .red_exp(red_exp), .green_exp(green_exp),
        .blue_exp(blue_exp), .threshold(threshold), .desired_bg_r(desired_bg_r),
        .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Reference: mean of the PE sums, saturated to one 8-bit channel.
    function automatic logic [7:0] avg_exp(input logic [31:0] v[NP]);
        logic [63:0] acc;
        acc = '0;
        for (int k = 0; k < NP; k++) acc = acc + {32'd0, v[k]};
        acc = acc / NP;
        return (acc > 64'd255) ? 8'd255 : acc[7:0];
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_pe_ctl"}, {pe_start_sum, pe_start_bg, pe_ack}, 0);
        check_val({tag, "_exp"}, {red_exp, green_exp, blue_exp}, 0);
        check_val({tag, "_cfg"}, {threshold, desired_bg_r, desired_bg_g, desired_bg_b}, 0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        start = 1'b0; host_ack = 1'b0; pe_sum_done = '0; pe_bg_done = '0;
        @(negedge Clk);
        Reset = 1'b0;
        prev_r = 0; prev_g = 0; prev_b = 0;
    endtask

    task automatic load_sums();
        for (int k = 0; k < NP; k++) begin
            red_sum_flat[k*SW +: SW]   = s_r[k];
            green_sum_flat[k*SW +: SW] = s_g[k];
            blue_sum_flat[k*SW +: SW]  = s_b[k];
        end
    endtask

    // One frame with bench-modelled PEs. bd[k] < 0 means PE k never
    // finishes its removal pass.
    task automatic run_frame(input string tag, input bit to_case);
        int sum_t0, bg_t0, last_sd, done_n, go_s, go_b, acks, acks_pre;
        bit finished, cfg_ok, busy_ok;
        logic [7:0] er, eg, eb;
        sum_t0 = -1; bg_t0 = -1; last_sd = -1; done_n = -1;
        go_s = 0; go_b = 0; acks = 0; acks_pre = 0;
        finished = 0; cfg_ok = 1; busy_ok = 1;
        er = avg_exp(s_r); eg = avg_exp(s_g); eb = avg_exp(s_b);
        load_sums();
        @(negedge Clk);
        threshold_in = cfg_thr; bg_r_in = cfg_r; bg_g_in = cfg_g; bg_b_in = cfg_b;
        start = 1'b1;
        for (int n = 0; n < 300 && !finished; n++) begin
            @(negedge Clk);
            start = 1'b0; host_ack = 1'b0; pe_sum_done = '0; pe_bg_done = '0;
            if (n == 0) begin
                check_val({tag, "_err_clr"}, err, 0);
                threshold_in = 8'($urandom); bg_r_in = 8'($urandom);
                bg_g_in = 8'($urandom); bg_b_in = 8'($urandom);
            end
            if (n == 4) start = 1'b1;
            if (n == 6) host_ack = 1'b1;
            if ({threshold, desired_bg_r, desired_bg_g, desired_bg_b} !==
                {cfg_thr, cfg_r, cfg_g, cfg_b}) cfg_ok = 0;
            if (busy !== 1'b1) busy_ok = 0;
            if (pe_ack === 1'b1) acks++;
            if (pe_start_sum !== '0) begin
                go_s++;
                sum_t0 = n;
                check_val({tag, "_exp_hold"}, {red_exp, green_exp, blue_exp},
                          {prev_r, prev_g, prev_b});
                pe_sum_done = '1;
            end
            if (sum_t0 >= 0)
                for (int k = 0; k < NP; k++)
                    if (n == sum_t0 + sd[k]) begin
                        pe_sum_done[k] = 1'b1;
                        last_sd = n;
                    end
            if (pe_start_bg !== '0) begin
                go_b++;
                bg_t0 = n;
                acks_pre = acks;
                pe_bg_done = '1;
            end
            if (bg_t0 >= 0)
                for (int k = 0; k < NP; k++)
                    if (bd[k] > 0 && n == bg_t0 + bd[k]) pe_bg_done[k] = 1'b1;
            if (done === 1'b1) begin
                finished = 1;
                done_n = n;
            end
        end
        pe_sum_done = '0; pe_bg_done = '0;
        check_val({tag, "_busy"}, busy_ok, 1);
        check_val({tag, "_cfg_hold"}, cfg_ok, 1);
        if (to_case) begin
`ifdef PE_SEQ_TIMEOUT_EN
            check_val({tag, "_to_done"}, finished, 1);
            check_val({tag, "_to_err"}, err, 1);
            check_val({tag, "_to_lat"}, (done_n - bg_t0 >= TO_C && done_n - bg_t0 <= TO_C + 2), 1);
`else
            check_val({tag, "_hang_done"}, finished, 0);
            check_val({tag, "_hang_busy"}, busy, 1);
`endif
        end else begin
            check_val({tag, "_finished"}, finished, 1);
            check_val({tag, "_err"}, err, 0);
        end
        if (finished) begin
            check_val({tag, "_red"}, red_exp, er);
            check_val({tag, "_green"}, green_exp, eg);
            check_val({tag, "_blue"}, blue_exp, eb);
            check_val({tag, "_go_sum"}, go_s, 1);
            check_val({tag, "_go_bg"}, go_b, 1);
            check_val({tag, "_acks"}, acks, 2);
            check_val({tag, "_ack_pre_bg"}, acks_pre, 1);
            check_val({tag, "_bg_after_sum"}, (bg_t0 > last_sd), 1);
            prev_r = er; prev_g = eg; prev_b = eb;
            host_ack = 1'b1;
            start = 1'b1;
            @(negedge Clk);
            host_ack = 1'b0;
            start = 1'b0;
            check_val({tag, "_done_clr"}, done, 0);
            check_val({tag, "_idle"}, busy, 0);
            @(negedge Clk);
            check_val({tag, "_start_rej"}, busy, 0);
        end else begin
            do_reset();
        end
    endtask

    task automatic rand_sums();
        for (int k = 0; k < NP; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                s_r[k] = $urandom_range(0, 600);
                s_g[k] = $urandom_range(0, 600);
                s_b[k] = $urandom_range(0, 600);
            end else begin
                s_r[k] = $urandom;
                s_g[k] = $urandom_range(0, 511);
                s_b[k] = $urandom;
            end
            sd[k] = $urandom_range(1, 12);
            bd[k] = $urandom_range(1, 12);
        end
        cfg_thr = 8'($urandom); cfg_r = 8'($urandom);
        cfg_g = 8'($urandom); cfg_b = 8'($urandom);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; host_ack = 1'b0;
        threshold_in = '0; bg_r_in = '0; bg_g_in = '0; bg_b_in = '0;
        pe_sum_done = '0; pe_bg_done = '0;
        red_sum_flat = '0; green_sum_flat = '0; blue_sum_flat = '0;
        prev_r = 0; prev_g = 0; prev_b = 0;
        repeat (3) @(negedge Clk);
        check_zero("rst");
        Reset = 1'b0;

        s_r = '{32'd100, 32'd101}; s_g = '{32'd200, 32'd200}; s_b = '{32'd7, 32'd8};
        sd = '{1, 1}; bd = '{2, 3};
        cfg_thr = 8'd60; cfg_r = 8'd106; cfg_g = 8'd168; cfg_b = 8'd79;
        run_frame("basic", 0);

        s_r = '{32'd50, 32'd70}; s_g = '{32'd3, 32'd4}; s_b = '{32'd511, 32'd1};
        sd = '{3, 9}; bd = '{5, 1};
        run_frame("stagger", 0);

        s_r = '{32'h1000, 32'h1000}; s_g = '{32'd255, 32'd255}; s_b = '{32'd256, 32'd257};
        sd = '{2, 2}; bd = '{1, 1};
        run_frame("sat", 0);

        // Reset in the middle of AVG.
        s_r = '{32'd10, 32'd20}; s_g = '{32'd30, 32'd40}; s_b = '{32'd50, 32'd60};
        load_sums();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        pe_sum_done = '1;
        @(negedge Clk);
        pe_sum_done = '1;
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge Clk);
                pe_sum_done = '0;
                if (pe_ack === 1'b1) seen = 1;
            end
            check_val("mid_ack_seen", seen, 1);
        end
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge Clk);
        Reset = 1'b0;
        prev_r = 0; prev_g = 0; prev_b = 0;

        s_r = '{32'd9, 32'd12}; s_g = '{32'd1, 32'd0}; s_b = '{32'd300, 32'd301};
        sd = '{4, 2}; bd = '{3, 3};
        cfg_thr = 8'd1; cfg_r = 8'd2; cfg_g = 8'd3; cfg_b = 8'd4;
        run_frame("post_rst", 0);

        for (int i = 0; i < 6; i++) begin
            rand_sums();
            run_frame($sformatf("rnd%0d", i), 0);
        end

        rand_sums();
        bd = '{2, -1};
        run_frame("timeout", 1);

        rand_sums();
        run_frame("after_to", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
